fetch_stage: RTL

Instruction-fetch (IF) stage and IF/ID pipeline register for the 8-bit, 24-bit-instruction pipelined processor. It sits directly upstream of decode:
- owns the program counter (`Current_Address`) and drives it to instruction memory;
- registers the returned instruction for decode;
- applies stall, flush and branch redirects from later stages;
- vectors the external `interrupt` pin to a fixed handler address, with a single-level saved return PC (`epc`).

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers the fetched instruction into IF/ID,
// and vectors a synchronized external interrupt to a fixed handler with one saved return PC.
module fetch_stage #(
    parameter logic [7:0]  RESET_PC   = 8'h00,
    parameter logic [7:0]  INT_VECTOR = 8'hF0,
    parameter logic [23:0] NOP        = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  Current_Address,
    input  logic [23:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic        reti,
    input  logic        interrupt,
    output logic [23:0] ins,
    output logic [7:0]  ins_pc,
    output logic        ins_valid,
    output logic        int_active,
    output logic [7:0]  epc
);

    typedef enum logic [2:0] {
        ACT_BRANCH,
        ACT_RETI,
        ACT_TAKE,
        ACT_STALL,
        ACT_FETCH
    } action_t;

    action_t     action;
    logic        int_sync1, int_sync2, int_prev;
    logic        pending;
    logic        int_rise;

    logic [7:0]  pc_next;
    logic [23:0] ins_next;
    logic [7:0]  ins_pc_next;
    logic        ins_valid_next;
    logic        int_active_next;
    logic [7:0]  epc_next;
    logic        pending_next;

    assign int_rise = int_sync2 & ~int_prev;

    // One winner per edge, in descending priority.
    always_comb begin
        action = ACT_FETCH;
        if (branch_taken)
            action = ACT_BRANCH;
        else if (reti && int_active)
            action = ACT_RETI;
        else if (pending && !int_active && !stall)
            action = ACT_TAKE;
        else if (stall)
            action = ACT_STALL;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        pc_next         = Current_Address;
        ins_next        = ins;
        ins_pc_next     = ins_pc;
        ins_valid_next  = ins_valid;
        int_active_next = int_active;
        epc_next        = epc;

        case (action)
            ACT_BRANCH: begin
                pc_next        = branch_target;
                ins_next       = NOP;
                ins_valid_next = 1'b0;
            end
            ACT_RETI: begin
                pc_next         = epc;
                int_active_next = 1'b0;
                ins_next        = NOP;
                ins_valid_next  = 1'b0;
            end
            ACT_TAKE: begin
                epc_next        = Current_Address;
                pc_next         = INT_VECTOR;
                int_active_next = 1'b1;
                ins_next        = NOP;
                ins_valid_next  = 1'b0;
            end
            ACT_STALL: begin
                if (flush) begin
                    ins_next       = NOP;
                    ins_valid_next = 1'b0;
                end
            end
            default: begin
                pc_next = Current_Address + 8'd1;
                if (flush) begin
                    ins_next       = NOP;
                    ins_valid_next = 1'b0;
                end else begin
                    ins_next       = imem_data;
                    ins_pc_next    = Current_Address;
                    ins_valid_next = 1'b1;
                end
            end
        endcase

        // A new edge arriving on the take edge merges into the request being serviced.
        pending_next = pending;
        if (action == ACT_TAKE)
            pending_next = 1'b0;
        else if (int_rise)
            pending_next = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_sync1       <= 1'b0;
            int_sync2       <= 1'b0;
            int_prev        <= 1'b0;
            pending         <= 1'b0;
            Current_Address <= RESET_PC;
            ins             <= NOP;
            ins_pc          <= 8'h00;
            ins_valid       <= 1'b0;
            int_active      <= 1'b0;
            epc             <= 8'h00;
        end else begin
            int_sync1       <= interrupt;
            int_sync2       <= int_sync1;
            int_prev        <= int_sync2;
            pending         <= pending_next;
            Current_Address <= pc_next;
            ins             <= ins_next;
            ins_pc          <= ins_pc_next;
            ins_valid       <= ins_valid_next;
            int_active      <= int_active_next;
            epc             <= epc_next;
        end
    end

endmodule
